inv_bist: RTL and testbench

INV_BIST -- requirements
Module: inv_bist

---
 rtl/inv_bist.sv | 80 ++++++++
 tb/tb_inv_bist.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/inv_bist.sv
// inv_bist: sweeps every N-bit stimulus vector, checks the response against x ^ MASK,
// and reports the mismatch count, the first failing vector and an overall pass flag.
module inv_bist #(
    parameter int             N      = 4,
    parameter logic [N-1:0]   MASK   = 4'b0101,
    parameter int             SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] y_in,
    output logic [N-1:0] x_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   fail_count,
    output logic [N-1:0] first_fail_vec,
    output logic         first_fail_valid
);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
    localparam logic [3:0] WAIT_LAST = 4'(SETTLE == 0 ? 0 : SETTLE - 1);
    state_t     state, state_nx;
    logic [3:0] wcnt;
    logic       last, mism, accept;
    assign last   = &x_out;
    assign mism   = y_in != (x_out ^ MASK);
    assign accept = state == IDLE && start && !abort;
    assign busy   = state != IDLE;
    assign done   = state == DONE && !abort;
    always_comb begin
        state_nx = state;
        if (state != IDLE && abort)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = accept ? DRIVE : IDLE;
                DRIVE:   state_nx = SETTLE == 0 ? CHECK : WAIT;
                WAIT:    state_nx = wcnt == WAIT_LAST ? CHECK : WAIT;
                CHECK:   state_nx = last ? DONE : DRIVE;
                default: state_nx = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wcnt             <= '0;
            x_out            <= '0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= state == WAIT ? wcnt + 4'd1 : '0;
            if (accept) begin
                x_out            <= '0;
                fail_count       <= '0;
                first_fail_valid <= 1'b0;
                pass             <= 1'b0;
            end
            // an abort cancels whatever the current cycle would have recorded
            if (state != IDLE && abort)
                pass <= 1'b0;
            else begin
                if (state == CHECK && mism) begin
                    fail_count <= fail_count + 1'b1;
                    if (!first_fail_valid) begin
                        first_fail_vec   <= x_out;
                        first_fail_valid <= 1'b1;
                    end
                end
                if (state == CHECK && !last)
                    x_out <= x_out + 1'b1;
                if (state == DONE)
                    pass <= fail_count == '0;
            end
        end
    end
endmodule

// File: tb/tb_inv_bist.sv
// tb_inv_bist: directed sweeps against a modelled device under test; a monitor pops
// the expected sweep result from a scoreboard queue on every done pulse.
module tb_inv_bist;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] y_in, x_out, first_fail_vec;
    logic [4:0] fail_count;
    logic       busy, done, pass, first_fail_valid;

    typedef struct {
        logic [4:0] fc;
        logic [3:0] ffv;
        logic       ffok;
        logic       ps;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int   checks = 0, errors = 0, cyc = 0, dones = 0;
    logic pend = 1'b0, pexp = 1'b0;

    inv_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y_in),
        .x_out(x_out), .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
    );

    // mode 0: good device, 1: y[0] stuck at 0, 2: wrong only at x=3
    assign y_in = mode == 2'd1 ? ((x_out ^ 4'b0101) & 4'b1110) :
                  (mode == 2'd2 && x_out == 4'd3) ? 4'b0111 : x_out ^ 4'b0101;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // cycle 1 is the cycle entered on the edge that samples start
    always @(posedge clk) begin
        if (rst_n && !busy && start && !abort) cyc = 1;
        else cyc++;
        #1;
        if (pend) begin
            chk("pass_after_done", pass, pexp);
            pend = 1'b0;
        end
        if (done) begin
            dones++;
            if (q.size() == 0) chk("unexpected_done", dones, dones - 1);
            else begin
                e = q.pop_front();
                chk("done_cycle", cyc, 65);
                chk("fail_count", fail_count, e.fc);
                chk("first_fail_vec", first_fail_vec, e.ffv);
                chk("first_fail_valid", first_fail_valid, e.ffok);
                chk("x_out_final", x_out, 4'hf);
                pend = 1'b1;
                pexp = e.ps;
            end
        end
    end

    task automatic go(input logic [1:0] m, input logic [4:0] fc, input logic [3:0] ffv,
                      input logic ffok, input logic ps);
        exp_t x;
        x.fc = fc; x.ffv = ffv; x.ffok = ffok; x.ps = ps;
        @(negedge clk) mode = m;
        q.push_back(x);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = dones;
        int n = 0;
        while (dones == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", dones, d0 + 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int d0;
        #2;
        chk("reset_outs", {x_out, busy, done, pass, fail_count, first_fail_vec, first_fail_valid}, 0);
        @(negedge clk) rst_n = 1'b1;

        go(2'd0, 5'd0, 4'd0, 1'b0, 1'b1); wait_done();
        go(2'd1, 5'd8, 4'd0, 1'b1, 1'b0); wait_done();
        go(2'd2, 5'd1, 4'd3, 1'b1, 1'b0); wait_done();

        // abort sampled on the 11th edge: only vectors 0 and 1 were checked
        @(negedge clk) mode = 2'd1;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        d0 = dones;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pass", pass, 0);
        chk("abort_keep_fc", fail_count, 5'd1);
        chk("abort_keep_ffv", {first_fail_valid, first_fail_vec}, 5'b10000);
        repeat (80) @(negedge clk);
        chk("abort_no_done", dones, d0);
        go(2'd0, 5'd0, 4'd0, 1'b0, 1'b1); wait_done();

        @(negedge clk) start = 1'b1;
        abort = 1'b1;
        @(negedge clk) start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        // start re-pulsed on edges 5 and 30 of the sweep
        go(2'd1, 5'd8, 4'd0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (24) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();

        // asynchronous reset in the middle of WAIT, between clock edges
        go(2'd0, 5'd0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("in_sweep_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", {x_out, busy, done, pass, fail_count, first_fail_vec, first_fail_valid}, 0);
        q.delete();
        d0 = dones;
        #1 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("reset_no_done", dones, d0);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
